rcv_drain_ctrl: RTL and testbench
=================================

// Module: rcv_drain_ctrl
// PURPOSE
// - Drains the UART receiver (rcv_block) autonomously: detects data_ready, pushes rx_data into a local FIFO, then acknowledges with a one-cycle data_read pulse.
// - Host side pops bytes at its own pace.
// - Keeps saturating statistics for framing errors, overrun errors and bytes dropped on FIFO full.
// - Sits between rcv_block outputs and the host/bus interface.
// PARAMETERS
// - DEPTH      8  FIFO entries; power of 2, >= 2.
// - CNT_W      8  width of each statistics counter.
// PORTS
// - clk            in   1             system clock; all state on rising edge.
// - rst            in   1             reset; asynchronous, active-high.
// - rx_data        in   8             rcv_block received byte.
// - data_ready     in   1             rcv_block byte-available flag (level).
// - framing_error  in   1             rcv_block framing error flag (level).
// - overrun_error  in   1             rcv_block overrun flag (level).
// - data_read      out  1             acknowledge to rcv_block; 1-cycle pulse.
// - pop            in   1             host pop request; ignored when empty.
// - pop_data       out  8             FIFO head (show-ahead); valid when !empty.
// - empty          out  1             FIFO empty.
// - full           out  1             FIFO full.
// - count          out  $clog2(DEPTH)+1  occupancy 0..DEPTH.
// - clr_stats      in   1             synchronous clear of all stat counters.
// - frame_err_cnt  out  CNT_W         rising edges of framing_error, saturating.
// - ovr_err_cnt    out  CNT_W         rising edges of overrun_error, saturating.
// - drop_cnt       out  CNT_W         bytes discarded because FIFO full, saturating.
// BEHAVIOUR
// - Reset (async, rst=1): state IDLE; data_read=0; FIFO empty (empty=1, full=0, count=0); pop_data=0.
//   - All counters 0; edge-detect registers 0.
//   - Reset mid-handshake aborts immediately. No pending byte is pushed.
// - FSM states: IDLE, CAPTURE, ACK, WAIT_CLR.
//   - IDLE -> CAPTURE when data_ready=1 is sampled.
//   - CAPTURE (1 cycle): push rx_data if count<DEPTH, or if pop=1 in the same cycle. Otherwise drop_cnt++. Then -> ACK.
//   - ACK (1 cycle): data_read=1. Then -> WAIT_CLR.
//   - WAIT_CLR: data_read=0. Stay while data_ready=1; -> IDLE when data_ready=0.
// - Latency:
//   - data_ready is first sampled high at edge E.
//   - The byte is written at edge E+1; empty falls after E+1.
//   - data_read is high during the cycle between E+2 and E+3.
// - Exactly one push and one data_read pulse occur per data_ready assertion. data_ready held high does not re-trigger.
// - FIFO:
//   - Circular buffer with rd/wr pointers of $clog2(DEPTH) bits. Pointers wrap DEPTH-1 -> 0.
//   - count is tracked separately.
//   - Push only: count+1. Pop only (!empty): count-1. Push and pop together: count unchanged, both pointers advance.
//   - pop while empty: no effect; pointers and count unchanged.
//   - full = (count==DEPTH); empty = (count==0). Both are registered-state derived, with no combinational path from pop.
// - Error statistics:
//   - framing_error and overrun_error are registered once. A counter increments on 0->1 of each flag.
//   - framing_error does not push: rcv_block does not assert data_ready for bad-stop-bit frames.
// - Counters saturate at 2^CNT_W-1 (no wrap).
//   - clr_stats=1 forces all three to 0 next edge.
//   - clr_stats takes priority over a same-cycle increment (result 0).
// - Counters and FIFO are independent: clr_stats does not touch FIFO contents.
// TESTING
// - Reset mid-ACK:
//   - Stimulus: rst pulse while data_read=1.
//   - Required: data_read=0 immediately (async), count=0, empty=1, all counters 0.
// - Single byte:
//   - Stimulus: data_ready=1 with rx_data=8'hA5; rcv model clears data_ready 1 cycle after data_read.
//   - Required: exactly one data_read pulse at E+2, pop_data=8'hA5, count=1; pop -> empty=1.
// - Fill and overflow:
//   - Stimulus: 10 bytes 8'h00..8'h09, no pops, DEPTH=8.
//   - Required: full=1, count=8, drop_cnt=2.
//   - Required: pops return 8'h00..8'h07 in order, then empty=1.
// - Push with pop while full:
//   - Stimulus: FIFO full; pop=1 coincides with CAPTURE of 8'h3C.
//   - Required: no drop, count stays 8, 8'h3C is the last byte popped.
// - Error edges and saturation (CNT_W=2):
//   - Stimulus: framing_error held high 20 cycles.
//   - Required: frame_err_cnt=1.
//   - Stimulus: 5 overrun_error pulses.
//   - Required: ovr_err_cnt=3 (saturated).
//   - Stimulus: clr_stats=1 coinciding with a new pulse.
//   - Required: counter=0.
// - Held data_ready / pop when empty:
//   - Stimulus: data_ready held high 50 cycles.
//   - Required: one push, one data_read pulse.
//   - Stimulus: pop while empty.
//   - Required: count stays 0, pointers unchanged.

Source files
------------

// File: rtl/rcv_drain_ctrl_if.sv
// Bundles the rcv_block-facing and host-facing signals of the receive drain controller.
// The slave modport is the controller's view; the master modport drives it.
interface rcv_drain_ctrl_if #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
);
    logic [7:0]               rx_data;
    logic                     data_ready;
    logic                     framing_error;
    logic                     overrun_error;
    logic                     data_read;
    logic                     pop;
    logic [7:0]               pop_data;
    logic                     empty;
    logic                     full;
    logic [$clog2(DEPTH):0]   count;
    logic                     clr_stats;
    logic [CNT_W-1:0]         frame_err_cnt;
    logic [CNT_W-1:0]         ovr_err_cnt;
    logic [CNT_W-1:0]         drop_cnt;

    modport slave (
        input  rx_data, data_ready, framing_error, overrun_error, pop, clr_stats,
        output data_read, pop_data, empty, full, count,
        output frame_err_cnt, ovr_err_cnt, drop_cnt
    );

    modport master (
        output rx_data, data_ready, framing_error, overrun_error, pop, clr_stats,
        input  data_read, pop_data, empty, full, count,
        input  frame_err_cnt, ovr_err_cnt, drop_cnt
    );
endinterface

// File: rtl/rcv_drain_ctrl.sv
// Autonomously drains rcv_block into a show-ahead FIFO, acknowledges each byte with a
// one-cycle data_read pulse, and keeps saturating error/drop statistics.
module rcv_drain_ctrl #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    rcv_drain_ctrl_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, CAPTURE, ACK, WAIT_CLR} state_t;

    state_t             r_state;
    logic               r_dataRead;
    logic [7:0]         r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [CW-1:0]      r_count;
    logic               r_frameErrQ;
    logic               r_ovrErrQ;
    logic [CNT_W-1:0]   r_frameCnt;
    logic [CNT_W-1:0]   r_ovrCnt;
    logic [CNT_W-1:0]   r_dropCnt;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_pop   = bus.pop && !w_empty;
    // A full FIFO still accepts the byte when the host frees a slot in the same cycle.
    assign w_push  = (r_state == CAPTURE) && (!w_full || w_pop);
    assign w_drop  = (r_state == CAPTURE) && !w_push;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_dataRead <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_dataRead <= 1'b0;
                    if (bus.data_ready) r_state <= CAPTURE;
                end
                CAPTURE: begin
                    r_dataRead <= 1'b0;
                    r_state    <= ACK;
                end
                ACK: begin
                    r_dataRead <= 1'b1;
                    r_state    <= WAIT_CLR;
                end
                WAIT_CLR: begin
                    r_dataRead <= 1'b0;
                    if (!bus.data_ready) r_state <= IDLE;
                end
                default: begin
                    r_dataRead <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr] <= bus.rx_data;
                r_wrPtr        <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) r_rdPtr <= r_rdPtr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Edge detectors keep tracking during a clear so a flag already high is not counted later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frameErrQ <= 1'b0;
            r_ovrErrQ   <= 1'b0;
            r_frameCnt  <= '0;
            r_ovrCnt    <= '0;
            r_dropCnt   <= '0;
        end else begin
            r_frameErrQ <= bus.framing_error;
            r_ovrErrQ   <= bus.overrun_error;
            if (bus.clr_stats) begin
                r_frameCnt <= '0;
                r_ovrCnt   <= '0;
                r_dropCnt  <= '0;
            end else begin
                if (bus.framing_error && !r_frameErrQ) r_frameCnt <= satInc(r_frameCnt);
                if (bus.overrun_error && !r_ovrErrQ)   r_ovrCnt   <= satInc(r_ovrCnt);
                if (w_drop)                            r_dropCnt  <= satInc(r_dropCnt);
            end
        end
    end

    assign bus.data_read     = r_dataRead;
    assign bus.pop_data      = r_mem[r_rdPtr];
    assign bus.empty         = w_empty;
    assign bus.full          = w_full;
    assign bus.count         = r_count;
    assign bus.frame_err_cnt = r_frameCnt;
    assign bus.ovr_err_cnt   = r_ovrCnt;
    assign bus.drop_cnt      = r_dropCnt;
endmodule

// File: tb/tb_rcv_drain_ctrl.sv
// Self-checking bench for rcv_drain_ctrl: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_rcv_drain_ctrl;
    localparam int DEPTH   = 8;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rcv_drain_ctrl_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    rcv_drain_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int testsRun    = 0;
    int testsFailed = 0;
    logic [7:0] modelQ [$];
    int modelDrop;
    int modelFrame;
    int modelOvr;
    int readPulses = 0;

    always @(negedge clk) if (bus.data_read === 1'b1) readPulses++;

    function automatic int satAdd(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic modelClear();
        modelQ.delete();
        modelDrop  = 0;
        modelFrame = 0;
        modelOvr   = 0;
    endtask

    task automatic checkState(input string where);
        checkOutput({where, ":count"}, 32'(bus.count), modelQ.size());
        checkOutput({where, ":empty"}, 32'(bus.empty), (modelQ.size() == 0) ? 1 : 0);
        checkOutput({where, ":full"},  32'(bus.full),  (modelQ.size() == DEPTH) ? 1 : 0);
        if (modelQ.size() > 0) checkOutput({where, ":pop_data"}, 32'(bus.pop_data), 32'(modelQ[0]));
        checkOutput({where, ":drop_cnt"},      32'(bus.drop_cnt),      modelDrop);
        checkOutput({where, ":frame_err_cnt"}, 32'(bus.frame_err_cnt), modelFrame);
        checkOutput({where, ":ovr_err_cnt"},   32'(bus.ovr_err_cnt),   modelOvr);
    endtask

    // rcv_block model: raise data_ready, optionally pop during the capture cycle,
    // check the acknowledge timing, then release data_ready after holdExtra more cycles.
    task automatic applyStimulus(input logic [7:0] d, input bit popInCap, input int holdExtra);
        int pulses0;
        pulses0 = readPulses;
        @(negedge clk);
        bus.rx_data    = d;
        bus.data_ready = 1'b1;
        @(negedge clk);
        if (popInCap) begin
            if (modelQ.size() > 0) checkOutput("capture_pop_data", 32'(bus.pop_data), 32'(modelQ[0]));
            bus.pop = 1'b1;
        end
        @(negedge clk);
        bus.pop = 1'b0;
        if (popInCap && modelQ.size() > 0) void'(modelQ.pop_front());
        if (modelQ.size() < DEPTH) modelQ.push_back(d);
        else modelDrop = satAdd(modelDrop);
        checkOutput("data_read_before_E2", 32'(bus.data_read), 0);
        @(negedge clk);
        checkOutput("data_read_at_E2", 32'(bus.data_read), 1);
        repeat (holdExtra) @(negedge clk);
        bus.data_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("one_data_read_pulse", readPulses - pulses0, 1);
    endtask

    task automatic popByte();
        @(negedge clk);
        if (modelQ.size() > 0) checkOutput("pop_data", 32'(bus.pop_data), 32'(modelQ[0]));
        bus.pop = 1'b1;
        @(negedge clk);
        bus.pop = 1'b0;
        if (modelQ.size() > 0) void'(modelQ.pop_front());
    endtask

    task automatic pulseError(input bit isOvr, input int len, input bit withClr);
        @(negedge clk);
        if (isOvr) bus.overrun_error = 1'b1;
        else       bus.framing_error = 1'b1;
        bus.clr_stats = withClr;
        if (withClr) begin
            modelDrop  = 0;
            modelFrame = 0;
            modelOvr   = 0;
        end else if (isOvr) modelOvr = satAdd(modelOvr);
        else                modelFrame = satAdd(modelFrame);
        @(negedge clk);
        bus.clr_stats = 1'b0;
        repeat (len - 1) @(negedge clk);
        bus.overrun_error = 1'b0;
        bus.framing_error = 1'b0;
        @(negedge clk);
    endtask

    task automatic clrStats();
        @(negedge clk);
        bus.clr_stats = 1'b1;
        @(negedge clk);
        bus.clr_stats = 1'b0;
        modelDrop  = 0;
        modelFrame = 0;
        modelOvr   = 0;
    endtask

    initial begin
        bus.rx_data       = 8'h00;
        bus.data_ready    = 1'b0;
        bus.framing_error = 1'b0;
        bus.overrun_error = 1'b0;
        bus.pop           = 1'b0;
        bus.clr_stats     = 1'b0;
        rst = 1'b1;
        modelClear();
        repeat (2) @(negedge clk);
        checkOutput("reset:data_read", 32'(bus.data_read), 0);
        checkOutput("reset:pop_data", 32'(bus.pop_data), 0);
        checkState("reset");
        rst = 1'b0;

        applyStimulus(8'hA5, 1'b0, 0);
        checkState("single_byte");
        popByte();
        checkState("single_byte_popped");

        for (int i = 0; i < 10; i++) applyStimulus(8'(i), 1'b0, 0);
        checkOutput("fill:full", 32'(bus.full), 1);
        checkOutput("fill:count", 32'(bus.count), 8);
        checkOutput("fill:drop_cnt", 32'(bus.drop_cnt), 2);
        for (int i = 0; i < 8; i++) begin
            checkOutput("fill:ordered_head", 32'(bus.pop_data), i);
            popByte();
        end
        checkState("fill_drained");

        for (int i = 0; i < 8; i++) applyStimulus(8'(8'h10 + i), 1'b0, 0);
        applyStimulus(8'h3C, 1'b1, 0);
        checkOutput("full_pop:drop_cnt", 32'(bus.drop_cnt), 2);
        checkOutput("full_pop:count", 32'(bus.count), 8);
        checkState("full_pop");
        for (int i = 0; i < 7; i++) popByte();
        checkOutput("full_pop:last_byte", 32'(bus.pop_data), 32'h3C);
        popByte();
        checkState("full_pop_drained");

        clrStats();
        pulseError(1'b0, 20, 1'b0);
        checkOutput("frame_held:frame_err_cnt", 32'(bus.frame_err_cnt), 1);
        for (int i = 0; i < 5; i++) pulseError(1'b1, 2, 1'b0);
        checkOutput("ovr_sat:ovr_err_cnt", 32'(bus.ovr_err_cnt), 3);
        pulseError(1'b1, 2, 1'b1);
        checkOutput("clr_priority:ovr_err_cnt", 32'(bus.ovr_err_cnt), 0);
        checkState("stats");

        applyStimulus(8'h55, 1'b0, 48);
        checkState("held_ready");
        popByte();
        popByte();
        checkState("pop_empty");
        applyStimulus(8'h66, 1'b0, 0);
        checkState("after_pop_empty");
        popByte();

        pulseError(1'b0, 1, 1'b0);
        applyStimulus(8'h77, 1'b0, 0);
        @(negedge clk);
        bus.rx_data    = 8'h88;
        bus.data_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("mid_ack:data_read_high", 32'(bus.data_read), 1);
        rst = 1'b1;
        #1;
        checkOutput("mid_ack:data_read", 32'(bus.data_read), 0);
        checkOutput("mid_ack:count", 32'(bus.count), 0);
        checkOutput("mid_ack:empty", 32'(bus.empty), 1);
        checkOutput("mid_ack:frame_err_cnt", 32'(bus.frame_err_cnt), 0);
        checkOutput("mid_ack:drop_cnt", 32'(bus.drop_cnt), 0);
        checkOutput("mid_ack:ovr_err_cnt", 32'(bus.ovr_err_cnt), 0);
        bus.data_ready = 1'b0;
        modelClear();
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 4))
                0, 1: applyStimulus(8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
                2:    popByte();
                3:    pulseError(1'($urandom_range(0, 1)), $urandom_range(1, 4), ($urandom_range(0, 7) == 0));
                default: clrStats();
            endcase
            checkState("random");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
